lshift_seq: RTL
===============

// Module: lshift_seq
// PURPOSE
//  Sequential variable left shifter for the 16-bit shifter datapath. Accepts one
//  operand plus a shift amount over a valid/ready handshake and shifts it by 2
//  bits per cycle, the same step the fixed 2-bit stage applies. An odd amount
//  finishes with a 1-bit step. Drives the widened result over a valid/ready
//  handshake to the downstream consumer. One operation is in flight at a time.
// PARAMETERS
//  WIDTH   16  operand width (entrada)
//  SHW     4   shift-amount width; max amount = 2**SHW-1
//  OUT_W   WIDTH+2**SHW-1 (31)  localparam, result width; no bit is ever lost
// PORTS
//  clk        in   1      clock, rising edge
//  reset      in   1      asynchronous, active-low; 0 = reset
//  in_valid   in   1      entrada/amount valid
//  in_ready   out  1      block can accept (IDLE only)
//  entrada    in   WIDTH  operand
//  amount     in   SHW    left-shift amount 0..2**SHW-1
//  out_valid  out  1      saida holds a finished result
//  out_ready  in   1      consumer takes saida
//  saida      out  OUT_W  entrada zero-extended, << amount
//  busy       out  1      state != IDLE
//  done_cnt   out  8      count of completed output handshakes, wraps
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, acc=0, rem=0, saida=0, out_valid=0,
//   busy=0, done_cnt=0. in_ready=1 while reset=0. Reset mid-op aborts the op
//   at once. No output is produced for the aborted op.
//  FSM states IDLE, SHIFT, DONE. Outputs are registered or state-decoded only.
//   IDLE:  in_ready=1. On in_valid at the edge: acc<={0,entrada}, rem<=amount.
//          Next state is DONE if amount==0, else SHIFT.
//   SHIFT: each edge, if rem>=2: acc<=acc<<2, rem<=rem-2. Else (rem==1):
//          acc<=acc<<1, rem<=0. Go to DONE on the edge where rem reaches 0.
//   DONE:  out_valid=1, saida=acc, held stable. On out_ready at the edge:
//          done_cnt<=done_cnt+1 (255->0), next state IDLE.
//  Latency: with n=amount, out_valid rises ceil(n/2) edges after the accepting
//   edge. For n=0 it rises on the accepting edge itself. Minimum throughput is
//   one op per 2 cycles (accept, then hand off).
//  in_ready=0 in SHIFT and DONE. in_valid there is ignored and nothing is latched.
//  out_ready outside DONE is ignored. A held-high out_ready completes the
//   handshake on the first DONE edge. out_valid is 0 on the following cycle.
//  Inputs are sampled only on the accepting edge. Later changes to entrada or
//   amount do not affect the op in flight.
//  Arithmetic: zero-fill from LSB. The MSBs of acc are never truncated because
//   OUT_W covers the max shift.
// TESTING
//  1 entrada=16'hFFFF, amount=2 -> out_valid 1 edge after accept,
//    saida=31'h0003FFFC (matches 2-bit stage output 18'h3FFFC).
//  2 entrada=16'h1234, amount=0 -> out_valid on the accepting edge,
//    saida=31'h00001234.
//  3 entrada=16'h8001, amount=15 -> out_valid 8 edges after accept,
//    saida=31'h40008000.
//  4 entrada=16'h0003, amount=5, out_ready=0 for 4 cycles in DONE ->
//    saida=31'h60 and out_valid held stable. in_valid pulses are ignored
//    (in_ready=0). The handshake happens when out_ready=1.
//  5 reset=0 asserted mid-SHIFT -> same cycle: out_valid=0, saida=0, busy=0,
//    done_cnt=0. After release, in_ready=1 and a new op behaves normally.
//  6 256 back-to-back ops with out_ready=1 -> done_cnt reads 0 after the 256th
//    handshake. Each saida is checked against entrada<<amount.

Source files
------------

// File: rtl/lshift_seq.sv
// ============================================================================
// Module   : lshift_seq
// Brief    : Sequential variable left shifter, 2 bits per cycle, with
//            valid/ready handshakes on both the operand and result sides.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lshift_seq #(
    parameter  int WIDTH = 16,
    parameter  int SHW   = 4,
    localparam int OUT_W = WIDTH + (2**SHW) - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] entrada,
    input  logic [SHW-1:0]   amount,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] saida,
    output logic             busy,
    output logic [7:0]       done_cnt
);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_SHIFT = 2'd1;
    localparam logic [1:0] c_S_DONE  = 2'd2;

    localparam logic [SHW-1:0] c_TWO = SHW'(2);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [OUT_W-1:0] r_acc;
    logic [SHW-1:0]   r_rem;
    logic [7:0]       r_done_cnt;

    logic             w_accept;
    logic             w_handoff;

    assign w_accept  = (r_state == c_S_IDLE) && in_valid;
    assign w_handoff = (r_state == c_S_DONE) && out_ready;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (in_valid) begin
                    w_next_state = (amount == '0) ? c_S_DONE : c_S_SHIFT;
                end
            end
            c_S_SHIFT: begin
                // Both a 2-bit step from rem==2 and the final 1-bit step empty rem.
                if (r_rem <= c_TWO) begin
                    w_next_state = c_S_DONE;
                end
            end
            c_S_DONE: begin
                if (out_ready) begin
                    w_next_state = c_S_IDLE;
                end
            end
            default: begin
                w_next_state = c_S_IDLE;
            end
        endcase
    end

    // Datapath: accumulator, remaining amount and completion counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc      <= '0;
            r_rem      <= '0;
            r_done_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_acc <= OUT_W'(entrada);
                r_rem <= amount;
            end else if (r_state == c_S_SHIFT) begin
                if (r_rem >= c_TWO) begin
                    r_acc <= r_acc << 2;
                    r_rem <= r_rem - c_TWO;
                end else begin
                    r_acc <= r_acc << 1;
                    r_rem <= '0;
                end
            end
            if (w_handoff) begin
                r_done_cnt <= r_done_cnt + 8'd1;
            end
        end
    end

    // Output decode
    always_comb begin
        in_ready  = (r_state == c_S_IDLE);
        out_valid = (r_state == c_S_DONE);
        busy      = (r_state != c_S_IDLE);
        saida     = (r_state == c_S_DONE) ? r_acc : '0;
        done_cnt  = r_done_cnt;
    end

endmodule

`default_nettype wire
